// File: rtl/cdr_tx_pkg.sv
// Shared types and constants for the CDR pattern transmitter and its PRBS7 generator.
package cdr_tx_pkg;

  typedef enum logic [1:0] {
    MODE_CLK  = 2'b00,
    MODE_PRBS = 2'b01,
    MODE_BYTE = 2'b10,
    MODE_IDLE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // Jitter LFSR: x^8+x^6+x^5+x^4, Fibonacci form shifting left.
  localparam logic [7:0] JIT_SEED = 8'hA5;
  localparam logic [7:0] JIT_TAPS = 8'b1011_1000;

  function automatic logic [7:0] jit_next(input logic [7:0] s);
    return {s[6:0], ^(s & JIT_TAPS)};
  endfunction

endpackage

// File: rtl/cdr_pattern_tx_if.sv
// Configuration and serial-output bundle of the CDR pattern transmitter.
interface cdr_pattern_tx_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic [DIV_W-1:0] bit_div;
  logic [1:0]       mode;
  logic [7:0]       pat_byte;
  logic             load;
  logic             err_inj;
  logic             tx_data;
  logic             bit_strobe;
  logic             frame_start;
  logic             err_pending;
  logic [1:0]       state_o;

  modport master (
    output en, bit_div, mode, pat_byte, load, err_inj,
    input  tx_data, bit_strobe, frame_start, err_pending, state_o
  );

  modport slave (
    input  en, bit_div, mode, pat_byte, load, err_inj,
    output tx_data, bit_strobe, frame_start, err_pending, state_o
  );
endinterface

// File: rtl/prbs7_lfsr.sv
// PRBS7 (x^7+x^6+1) generator shared with the CDR-side checker; bit_o is the current MSB.
module prbs7_lfsr
  import cdr_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  input  logic reseed,
  output logic bit_o,
  output logic at_seed
);

  logic [6:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed) begin
      lfsr_d = PRBS7_SEED;
    end else if (adv) begin
      // The all-zero lock-up state is escaped by reloading the seed.
      lfsr_d = (lfsr_q == '0) ? PRBS7_SEED : {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= PRBS7_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign bit_o   = lfsr_q[6];
  assign at_seed = (lfsr_q == PRBS7_SEED);

endmodule

// File: rtl/cdr_pattern_tx.sv
// NRZ pattern transmitter: preamble, then clock / PRBS7 / byte / idle at a programmable bit period.
// Optional macro CDR_TX_JITTER_EN adds +-1 cycle pseudo-random period jitter.
module cdr_pattern_tx
  import cdr_tx_pkg::*;
#(
  parameter int DIV_W         = 8,
  parameter int PREAMBLE_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  cdr_pattern_tx_if.slave   bus
);

  localparam int PRE_W = $clog2(PREAMBLE_BITS + 1);

  state_e           st_q, st_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, limit;
  logic [7:0]       pat_q, pat_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d, idx_use;
  logic             restart_q, restart_d, err_q, err_d;
  logic             tx_q, tx_d, stb_q, stb_d, frm_q, frm_d;
  logic             adv, reseed, prbs_bit, prbs_at_seed, wrap, run_bit, run_frm, apply_err;

  prbs7_lfsr u_prbs (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .reseed  (reseed),
    .bit_o   (prbs_bit),
    .at_seed (prbs_at_seed)
  );

`ifdef CDR_TX_JITTER_EN
  logic [7:0]       jit_q, jit_d;
  logic [1:0]       jsel_q, jsel_d;
  logic [DIV_W-1:0] base;

  always_comb begin
    jit_d  = jit_next(jit_q);
    jsel_d = stb_d ? jit_q[1:0] : jsel_q;
    base   = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;
    case (jsel_q)
      2'b01:   limit = base;
      2'b10:   limit = base - DIV_W'(2);
      default: limit = base - DIV_W'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jit_q  <= JIT_SEED;
      jsel_q <= 2'b00;
    end else begin
      jit_q  <= jit_d;
      jsel_q <= jsel_d;
    end
  end
`else
  always_comb limit = ((div_q < DIV_W'(2)) ? DIV_W'(2) : div_q) - DIV_W'(1);
`endif

  // RUN pattern bit for the current position; the first RUN bit always uses position 0.
  always_comb begin
    idx_use = (st_q == ST_RUN) ? idx_q : 3'd0;
    run_bit = 1'b0;
    run_frm = 1'b0;
    case (mode_q)
      MODE_CLK:  begin run_bit = ~idx_use[0];            run_frm = ~idx_use[0];       end
      MODE_PRBS: begin run_bit = prbs_bit;               run_frm = prbs_at_seed;      end
      MODE_BYTE: begin run_bit = pat_q[3'd7 - idx_use];  run_frm = (idx_use == 3'd0); end
      default:   begin run_bit = 1'b0;                   run_frm = 1'b0;              end
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    st_d      = st_q;
    cnt_d     = cnt_q + DIV_W'(1);
    pre_d     = pre_q;
    idx_d     = idx_q;
    restart_d = restart_q;
    tx_d      = tx_q;
    stb_d     = 1'b0;
    frm_d     = 1'b0;
    adv       = 1'b0;
    reseed    = 1'b0;
    apply_err = 1'b0;
    div_d     = bus.load ? bus.bit_div : div_q;
    mode_d    = bus.load ? mode_e'(bus.mode) : mode_q;
    pat_d     = bus.load ? bus.pat_byte : pat_q;
    wrap      = (cnt_q >= limit);

    if (!bus.en) begin
      st_d      = ST_IDLE;
      cnt_d     = '0;
      pre_d     = '0;
      idx_d     = '0;
      restart_d = 1'b0;
      tx_d      = 1'b0;
    end else if (st_q == ST_IDLE) begin
      st_d   = ST_SYNC;
      cnt_d  = '0;
      tx_d   = 1'b1;
      stb_d  = 1'b1;
      pre_d  = PRE_W'(1);
      reseed = 1'b1;
    end else if (wrap) begin
      cnt_d = '0;
      stb_d = 1'b1;
      if (restart_q) begin
        st_d      = ST_SYNC;
        tx_d      = 1'b1;
        pre_d     = PRE_W'(1);
        reseed    = 1'b1;
        restart_d = 1'b0;
      end else if (st_q == ST_SYNC && pre_q != PRE_W'(PREAMBLE_BITS)) begin
        tx_d  = ~pre_q[0];
        pre_d = pre_q + PRE_W'(1);
      end else begin
        st_d      = ST_RUN;
        apply_err = err_q;
        tx_d      = run_bit ^ err_q;
        frm_d     = run_frm;
        idx_d     = idx_use + 3'd1;
        adv       = (mode_q == MODE_PRBS);
      end
    end

    // A reload while active takes effect at the next bit boundary (after this edge).
    if (bus.load && bus.en && st_q != ST_IDLE) restart_d = 1'b1;

    err_d = bus.en && !apply_err && (err_q || bus.err_inj);
  end

  // NOTE: non-blocking assignments make every flop sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(2);
      mode_q    <= MODE_CLK;
      pat_q     <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
      tx_q      <= 1'b0;
      stb_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      restart_q <= restart_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
      stb_q     <= stb_d;
      frm_q     <= frm_d;
    end
  end

  assign bus.tx_data     = tx_q;
  assign bus.bit_strobe  = stb_q;
  assign bus.frame_start = frm_q;
  assign bus.err_pending = err_q;
  assign bus.state_o     = st_q;

endmodule

// File: tb/tb_cdr_pattern_tx.sv
// Directed bench for cdr_pattern_tx: vector table per mode plus hand-written multi-cycle sequences.
module tb_cdr_pattern_tx;
  import cdr_tx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdr_pattern_tx_if #(.DIV_W(8)) bus ();
  cdr_pattern_tx #(.DIV_W(8), .PREAMBLE_BITS(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [1:0] mode;
    logic [7:0] div;
    logic [7:0] pat;
    int         per;
    logic [7:0] bits;
    logic [7:0] frms;
  } vec_t;

  vec_t vecs [6];
  logic gold [0:253];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_bit(output logic b, output logic f, output int cyc);
    tick();
    cyc = 1;
    while (!bus.bit_strobe && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!bus.bit_strobe) begin
      n_vec++;
      n_bad++;
      $display("FAIL strobe_timeout: no bit_strobe within %0d cycles", cyc);
    end
    b = bus.tx_data;
    f = bus.frame_start;
  endtask

  task automatic restart(input logic [1:0] mode, input logic [7:0] div, input logic [7:0] pat);
    bus.en = 1'b0;
    tick();
    tick();
    bus.mode     = mode;
    bus.bit_div  = div;
    bus.pat_byte = pat;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.en   = 1'b1;
  endtask

  // Collects the 16 SYNC bits; with first_done the leading 1 was already observed.
  task automatic check_preamble(input string tag, input int per, input bit first_done);
    logic b, f;
    int cyc, bad_per;
    logic [15:0] bits;
    logic any_f, st_ok;
    bits = first_done ? 16'h0001 : 16'h0000;
    any_f = 1'b0; st_ok = 1'b1; bad_per = 0;
    for (int i = (first_done ? 1 : 0); i < 16; i++) begin
      next_bit(b, f, cyc);
      bits = {bits[14:0], b};
      any_f |= f;
      if (i > 0 && cyc != per) bad_per++;
      if (bus.state_o != 2'(ST_SYNC)) st_ok = 1'b0;
    end
    check({tag, "_pre_bits"},   32'(bits),    32'h0000_AAAA);
    check({tag, "_pre_frame"},  32'(any_f),   32'd0);
    check({tag, "_pre_period"}, 32'(bad_per), 32'd0);
    check({tag, "_pre_state"},  32'(st_ok),   32'd1);
  endtask

  task automatic get_run(input int n, input int per, output logic [7:0] bits,
                         output logic [7:0] frms, output int bad_per);
    logic b, f;
    int cyc;
    bits = '0; frms = '0; bad_per = 0;
    for (int i = 0; i < n; i++) begin
      next_bit(b, f, cyc);
      bits = {bits[6:0], b};
      frms = {frms[6:0], f};
      if (cyc != per) bad_per++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb, rf;
    logic b, f;
    int bp, cyc, ones, nfrm, ndiff, first_diff;
    logic obs [0:39];

    vecs[0] = '{MODE_CLK,  8'd4, 8'h00, 4, 8'hAA, 8'hAA};
    vecs[1] = '{MODE_PRBS, 8'd2, 8'h00, 2, 8'hFE, 8'h80};
    vecs[2] = '{MODE_BYTE, 8'd3, 8'hC5, 3, 8'hC5, 8'h80};
    vecs[3] = '{MODE_IDLE, 8'd5, 8'h00, 5, 8'h00, 8'h00};
    vecs[4] = '{MODE_PRBS, 8'd0, 8'h00, 2, 8'hFE, 8'h80};
    vecs[5] = '{MODE_BYTE, 8'd1, 8'h3A, 2, 8'h3A, 8'h80};

    rst = 1'b1;
    bus.en = 1'b0; bus.bit_div = '0; bus.mode = '0; bus.pat_byte = '0;
    bus.load = 1'b0; bus.err_inj = 1'b0;
    #12;
    check("rst_tx",    32'(bus.tx_data),     32'd0);
    check("rst_stb",   32'(bus.bit_strobe),  32'd0);
    check("rst_frm",   32'(bus.frame_start), 32'd0);
    check("rst_err",   32'(bus.err_pending), 32'd0);
    check("rst_state", 32'(bus.state_o),     32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      restart(vecs[v].mode, vecs[v].div, vecs[v].pat);
      check_preamble($sformatf("v%0d", v), vecs[v].per, 1'b0);
      get_run(8, vecs[v].per, rb, rf, bp);
      check($sformatf("v%0d_bits", v),   32'(rb), 32'(vecs[v].bits));
      check($sformatf("v%0d_frame", v),  32'(rf), 32'(vecs[v].frms));
      check($sformatf("v%0d_period", v), 32'(bp), 32'd0);
      check($sformatf("v%0d_state", v),  32'(bus.state_o), 32'(ST_RUN));
    end

    // PRBS7: period 127, 64 ones per period, frame_start once per period.
    restart(MODE_PRBS, 8'd2, 8'h00);
    check_preamble("prbs", 2, 1'b0);
    ones = 0; nfrm = 0; ndiff = 0;
    for (int i = 0; i < 254; i++) begin
      next_bit(b, f, cyc);
      gold[i] = b;
      if (i < 127 && b) ones++;
      if (f) nfrm++;
      if ((i == 0 || i == 127) && !f) ndiff++;
    end
    for (int i = 0; i < 127; i++) if (gold[i] !== gold[i+127]) ndiff++;
    check("prbs_ones",   32'(ones),  32'd64);
    check("prbs_frames", 32'(nfrm),  32'd2);
    check("prbs_repeat", 32'(ndiff), 32'd0);

    // Error injection after RUN bit 20; a second pulse while pending is absorbed.
    restart(MODE_PRBS, 8'd4, 8'h00);
    check_preamble("err", 4, 1'b0);
    for (int i = 0; i < 40; i++) begin
      next_bit(b, f, cyc);
      obs[i] = b;
      if (i == 21) check("err_cleared", 32'(bus.err_pending), 32'd0);
      if (i == 20) begin
        bus.err_inj = 1'b1; tick(); bus.err_inj = 1'b0;
        check("err_pend_a", 32'(bus.err_pending), 32'd1);
        tick();
        bus.err_inj = 1'b1; tick(); bus.err_inj = 1'b0;
        check("err_pend_b", 32'(bus.err_pending), 32'd1);
      end
    end
    ndiff = 0; first_diff = -1;
    for (int i = 0; i < 40; i++) begin
      if (obs[i] !== gold[i]) begin
        ndiff++;
        if (first_diff < 0) first_diff = i;
      end
    end
    check("err_ndiff", 32'(ndiff),      32'd1);
    check("err_index", 32'(first_diff), 32'd21);

    // Reload mid-RUN: preamble restarts at the next boundary with the new period.
    restart(MODE_CLK, 8'd4, 8'h00);
    check_preamble("ld0", 4, 1'b0);
    get_run(3, 4, rb, rf, bp);
    check("ld_run_before", 32'(rb), 32'h05);
    bus.bit_div = 8'd6; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    next_bit(b, f, cyc);
    check("ld_first_bit",   32'(b),             32'd1);
    check("ld_first_state", 32'(bus.state_o),   32'(ST_SYNC));
    check("ld_first_gap",   32'(cyc + 1),       32'd6);
    check_preamble("ld1", 6, 1'b1);
    get_run(4, 6, rb, rf, bp);
    check("ld_run_bits",   32'(rb), 32'h0A);
    check("ld_run_frame",  32'(rf), 32'h0A);
    check("ld_run_period", 32'(bp), 32'd0);

    // en dropped mid-bit while an injection is pending.
    next_bit(b, f, cyc);
    check("en_pre_tx", 32'(b), 32'd1);
    tick();
    bus.err_inj = 1'b1; tick(); bus.err_inj = 1'b0;
    check("en_pend", 32'(bus.err_pending), 32'd1);
    bus.en = 1'b0;
    tick();
    check("en_tx",    32'(bus.tx_data),     32'd0);
    check("en_stb",   32'(bus.bit_strobe),  32'd0);
    check("en_state", 32'(bus.state_o),     32'(ST_IDLE));
    check("en_err",   32'(bus.err_pending), 32'd0);

    // Asynchronous reset mid-bit, then default configuration after release.
    restart(MODE_PRBS, 8'd2, 8'h00);
    check_preamble("ar0", 2, 1'b0);
    next_bit(b, f, cyc);
    bus.err_inj = 1'b1; tick(); bus.err_inj = 1'b0;
    check("ar_pend",  32'(bus.err_pending), 32'd1);
    check("ar_pre_tx", 32'(bus.tx_data),    32'd1);
    #3 rst = 1'b1;
    #1;
    check("ar_tx",    32'(bus.tx_data),     32'd0);
    check("ar_state", 32'(bus.state_o),     32'(ST_IDLE));
    check("ar_err",   32'(bus.err_pending), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_preamble("ar1", 2, 1'b0);
    get_run(2, 2, rb, rf, bp);
    check("ar_dflt_bits",   32'(rb), 32'h02);
    check("ar_dflt_frame",  32'(rf), 32'h02);
    check("ar_dflt_period", 32'(bp), 32'd0);

    // Restart reproduces the identical PRBS sequence.
    restart(MODE_PRBS, 8'd2, 8'h00);
    check_preamble("rep", 2, 1'b0);
    ndiff = 0;
    for (int i = 0; i < 40; i++) begin
      next_bit(b, f, cyc);
      if (b !== gold[i]) ndiff++;
    end
    check("rep_seq", 32'(ndiff), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
